// File: rtl/prio_buf_pkg.sv
// Shared constants and types for the priority buffer controller.
package prio_buf_pkg;

  // Packet field layout: valid flag on top, 16-bit timestamp below it.
  localparam int unsigned VALID_BIT = 48;
  localparam int unsigned TS_MSB    = 47;
  localparam int unsigned TS_LSB    = 32;

  // Width of the route-info word stored alongside each packet.
  localparam int unsigned ROUTE_W = 16;

  // Flush sequencing states.
  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/prio_buffer_ctrl_free_slot_finder.sv
// Lowest-index priority encoder: finds the first bit of vec equal to FIND_SET.
// With FIND_SET=0 it locates the lowest free slot of a valid vector; with
// FIND_SET=1 it locates the lowest asserted bit of an eligibility vector.
module free_slot_finder #(
  parameter int unsigned N        = 4,
  parameter int unsigned IDX_W    = 2,
  parameter bit          FIND_SET = 1'b0
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i] == FIND_SET) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/prio_buffer_ctrl.sv
// Per-output-port high/low priority packet buffers feeding the switch
// allocator: slot allocation, grant release, starvation promotion and flush.
module prio_buffer_ctrl
  import prio_buf_pkg::*;
#(
  parameter int unsigned PACKET_SIZE = 49,
  parameter int unsigned BUFFER_SIZE = 4,
  parameter int unsigned AGE_W       = 8,
  parameter int unsigned AGE_LIMIT   = 64
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [PACKET_SIZE-1:0]                  in_packet,
  input  logic [ROUTE_W-1:0]                      in_route_info,
  input  logic                                    in_high,
  output logic                                    in_ready_high,
  output logic                                    in_ready_low,
  input  logic [15:0]                             grant_pos,
  input  logic                                    grant_valid,
  input  logic                                    grant_in_high,
  output logic [BUFFER_SIZE-1:0][PACKET_SIZE-1:0] buffer_high_prior,
  output logic [BUFFER_SIZE-1:0][ROUTE_W-1:0]     buffer_high_prior_route_info,
  output logic [BUFFER_SIZE-1:0][PACKET_SIZE-1:0] buffer_low_prior,
  output logic [BUFFER_SIZE-1:0][ROUTE_W-1:0]     buffer_low_prior_route_info,
  output logic [2:0]                              high_count,
  output logic [2:0]                              low_count,
  input  logic                                    flush_req,
  output logic                                    flush_done,
  output logic                                    err_bad_grant
);

  localparam int unsigned    IDX_W   = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;
  localparam logic [2:0]     CAP     = 3'(BUFFER_SIZE);
  localparam logic [AGE_W-1:0] AGE_MAX = '1;
  localparam logic [AGE_W-1:0] AGE_THR = AGE_W'(AGE_LIMIT);

  logic [BUFFER_SIZE-1:0][PACKET_SIZE-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [BUFFER_SIZE-1:0][ROUTE_W-1:0]     hi_r_q, hi_r_d, lo_r_q, lo_r_d;
  logic [BUFFER_SIZE-1:0][AGE_W-1:0]       age_q, age_d;
  logic [2:0]                              high_count_q, high_count_d;
  logic [2:0]                              low_count_q, low_count_d;
  logic                                    err_q, flush_done_q;
  state_e                                  state_q;

  logic [BUFFER_SIZE-1:0] valid_hi, valid_lo, aged;
  logic [IDX_W-1:0]       free_hi_idx, free_lo_idx, aged_idx, gidx;
  logic                   free_hi_found, free_lo_found, aged_found;
  logic                   wr_hi, wr_lo, grant_in_range, gslot_valid;
  logic                   grant_hi, grant_lo, bad_grant, promo;

  // Slot validity, grant decode and promotion eligibility from registered state.
  always_comb begin
    for (int i = 0; i < BUFFER_SIZE; i++) begin
      valid_hi[i] = hi_q[i][VALID_BIT];
      valid_lo[i] = lo_q[i][VALID_BIT];
    end
    gidx           = grant_pos[IDX_W-1:0];
    grant_in_range = grant_pos < 16'(BUFFER_SIZE);
    gslot_valid    = grant_in_range && (grant_in_high ? valid_hi[gidx] : valid_lo[gidx]);
    grant_hi       = grant_valid && gslot_valid && grant_in_high;
    grant_lo       = grant_valid && gslot_valid && !grant_in_high;
    bad_grant      = grant_valid && !gslot_valid;
    // A same-cycle grant on a low slot beats its promotion.
    for (int i = 0; i < BUFFER_SIZE; i++) begin
      aged[i] = valid_lo[i] && (age_q[i] >= AGE_THR) && !(grant_lo && gidx == IDX_W'(i));
    end
  end

  // Ready is derived from registered state only; resets force it low.
  always_comb begin
    in_ready_high = rst_n && (state_q == RUN) && (high_count_q < CAP);
    in_ready_low  = rst_n && (state_q == RUN) && (low_count_q < CAP);
    wr_hi = in_packet[VALID_BIT] && in_high && in_ready_high && free_hi_found;
    wr_lo = in_packet[VALID_BIT] && !in_high && in_ready_low && free_lo_found;
    promo = aged_found && (high_count_q < CAP) && !wr_hi && free_hi_found;
  end

  // The high free-slot search serves both the write target and the promotion target.
  free_slot_finder #(.N(BUFFER_SIZE), .IDX_W(IDX_W), .FIND_SET(1'b0)) u_free_hi (
    .vec   (valid_hi),
    .idx   (free_hi_idx),
    .found (free_hi_found)
  );

  free_slot_finder #(.N(BUFFER_SIZE), .IDX_W(IDX_W), .FIND_SET(1'b0)) u_free_lo (
    .vec   (valid_lo),
    .idx   (free_lo_idx),
    .found (free_lo_found)
  );

  free_slot_finder #(.N(BUFFER_SIZE), .IDX_W(IDX_W), .FIND_SET(1'b1)) u_aged (
    .vec   (aged),
    .idx   (aged_idx),
    .found (aged_found)
  );

  // Next buffer contents, ages and counts.
  always_comb begin
    hi_d   = hi_q;
    hi_r_d = hi_r_q;
    lo_d   = lo_q;
    lo_r_d = lo_r_q;
    for (int i = 0; i < BUFFER_SIZE; i++) begin
      if (!valid_lo[i])            age_d[i] = '0;
      else if (age_q[i] == AGE_MAX) age_d[i] = age_q[i];
      else                         age_d[i] = age_q[i] + AGE_W'(1);
    end
    if (grant_hi) begin
      hi_d[gidx]   = '0;
      hi_r_d[gidx] = '0;
    end
    if (wr_hi) begin
      hi_d[free_hi_idx]   = in_packet;
      hi_r_d[free_hi_idx] = in_route_info;
    end
    if (promo) begin
      hi_d[free_hi_idx]   = lo_q[aged_idx];
      hi_r_d[free_hi_idx] = lo_r_q[aged_idx];
      lo_d[aged_idx]      = '0;
      lo_r_d[aged_idx]    = '0;
      age_d[aged_idx]     = '0;
    end
    if (grant_lo) begin
      lo_d[gidx]   = '0;
      lo_r_d[gidx] = '0;
      age_d[gidx]  = '0;
    end
    if (wr_lo) begin
      lo_d[free_lo_idx]   = in_packet;
      lo_r_d[free_lo_idx] = in_route_info;
      age_d[free_lo_idx]  = '0;
    end
    high_count_d = high_count_q + {2'b0, wr_hi} + {2'b0, promo} - {2'b0, grant_hi};
    low_count_d  = low_count_q + {2'b0, wr_lo} - {2'b0, promo} - {2'b0, grant_lo};
  end

  // Buffer, age and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q         <= '0;
      hi_r_q       <= '0;
      lo_q         <= '0;
      lo_r_q       <= '0;
      age_q        <= '0;
      high_count_q <= '0;
      low_count_q  <= '0;
    end else begin
      hi_q         <= hi_d;
      hi_r_q       <= hi_r_d;
      lo_q         <= lo_d;
      lo_r_q       <= lo_r_d;
      age_q        <= age_d;
      high_count_q <= high_count_d;
      low_count_q  <= low_count_d;
    end
  end

  // Sticky bad-grant flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         err_q <= 1'b0;
    else if (bad_grant) err_q <= 1'b1;
  end

  // Flush sequencer; flush_done is high exactly while in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      flush_done_q <= 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          flush_done_q <= 1'b0;
          if (flush_req) state_q <= DRAIN;
        end
        DRAIN: begin
          if (high_count_q == 3'd0 && low_count_q == 3'd0) begin
            state_q      <= DONE;
            flush_done_q <= 1'b1;
          end
        end
        DONE: begin
          flush_done_q <= 1'b0;
          state_q      <= flush_req ? DRAIN : RUN;
        end
        default: begin
          state_q      <= RUN;
          flush_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign buffer_high_prior            = hi_q;
  assign buffer_high_prior_route_info = hi_r_q;
  assign buffer_low_prior             = lo_q;
  assign buffer_low_prior_route_info  = lo_r_q;
  assign high_count                   = high_count_q;
  assign low_count                    = low_count_q;
  assign flush_done                   = flush_done_q;
  assign err_bad_grant                = err_q;

endmodule

// File: doc/prio_buffer_ctrl.md
Name: prio_buffer_ctrl

Overview:
Owns the per-output-port high- and low-priority packet buffers that feed the ring switch allocator.
- Accepts incoming packets into the lowest free slot of the requested class.
- Frees slots when the allocator reports a grant.
- Promotes starved low-priority entries into the high-priority buffer.
- Supports a drain/flush sequence for reconfiguration.
- Sits between the ring input stage and switch_allocator; its buffer and route-info outputs connect directly to the allocator's buffer inputs.

Parameters:
PACKET_SIZE, 49, packet width; bit PACKET_SIZE-1 is the valid flag, bits 47:32 are the timestamp.
BUFFER_SIZE, 4, entries per priority class.
AGE_W, 8, width of the per-slot low-priority age counter.
AGE_LIMIT, 64, age at which a low-priority entry becomes eligible for promotion.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_packet  in  PACKET_SIZE  incoming packet; write request when MSB=1
in_route_info  in  16  route info stored with the packet
in_high  in  1  1 = high class, 0 = low class
in_ready_high  out  1  high class can accept this cycle
in_ready_low  out  1  low class can accept this cycle
grant_pos  in  16  slot index granted by the allocator
grant_valid  in  1  grant strobe
grant_in_high  in  1  granted slot is in the high class
buffer_high_prior  out  PACKET_SIZE x BUFFER_SIZE  high-class entries (0 = empty)
buffer_high_prior_route_info  out  16 x BUFFER_SIZE  high-class route info
buffer_low_prior  out  PACKET_SIZE x BUFFER_SIZE  low-class entries
buffer_low_prior_route_info  out  16 x BUFFER_SIZE  low-class route info
high_count  out  3  high-class occupancy
low_count  out  3  low-class occupancy
flush_req  in  1  request drain
flush_done  out  1  one-cycle pulse when drained
err_bad_grant  out  1  sticky: a grant targeted an empty or out-of-range slot

Behaviour:
- Reset (async, rst_n=0):
  - All entries, route info, age counters and counts are 0.
  - err_bad_grant=0, flush_done=0, FSM in RUN.
  - in_ready_* are forced 0 while rst_n=0.
- Entry validity:
  - An entry is valid iff its MSB is 1.
  - A freed entry is written to all zeros, and its route info is cleared to 0.
- Ready:
  - in_ready_high = (state==RUN) && high_count<BUFFER_SIZE; in_ready_low uses low_count the same way.
  - Both are combinational from registered state only; there is no same-cycle bypass of a release.
- Write:
  - A write occurs when in_packet MSB=1 and the selected class's ready=1.
  - Packet and route info are stored at the next clk edge into the lowest-index free slot, where the free vector is taken from registered state at the start of the cycle.
  - A request while ready=0 is dropped silently; the upstream must hold the packet.
- Release:
  - On grant_valid, the slot grant_pos of the class given by grant_in_high is cleared at the next edge.
  - If grant_pos>=BUFFER_SIZE or the slot is already empty: no change, and err_bad_grant is set (cleared only by reset).
  - A slot freed this cycle is usable for writes from the next cycle.
- Write and release in the same class, same cycle: both happen. Count changes by +1-1=0. The write lands in a slot that was free before the release.
- Aging:
  - Each valid low slot's age counter increments by 1 per cycle and saturates at 2^AGE_W-1.
  - The counter is cleared when the slot is written, freed or promoted.
- Promotion:
  - Conditions: some low slot has age>=AGE_LIMIT, high_count<BUFFER_SIZE, no high write this cycle, and that low slot is not being granted this cycle.
  - Action: at the next edge, move the lowest-index eligible low entry (packet plus route info) into the lowest free high slot and clear the low slot.
  - At most one promotion per cycle. high_count+1 and low_count-1, combined with any concurrent grant or write effects.
  - A grant on the same low slot in the same cycle wins; that slot is not promoted.
- Counts: registered, equal to the popcount of valid entries after every edge, range 0..BUFFER_SIZE.
- FSM states: RUN, DRAIN, DONE.
  - RUN -> DRAIN when flush_req=1.
  - In DRAIN, both ready outputs are 0; grants and promotion continue.
  - DRAIN -> DONE when high_count==0 && low_count==0.
  - DONE asserts flush_done for exactly one cycle, then returns to RUN. If flush_req is still 1 at that point, the FSM goes straight back to DRAIN.
  - A flush_req arriving while already empty takes RUN -> DRAIN -> DONE, so flush_done pulses 2 cycles after the request.
- Reset mid-operation (any state): everything returns to reset values immediately. No flush_done pulse is emitted.

Decomposition:
- Shared package prio_buf_pkg holds:
  - field constants VALID_BIT and TS_MSB/TS_LSB (47/32);
  - the state enum {RUN, DRAIN, DONE};
  - the route-info width (16).
- One natural sub-module, free_slot_finder: lowest-index-free priority encoder returning index plus found flag. It is instantiated for high-write, low-write and promotion-target selection; a second instance mode finds the lowest eligible aged slot.

Test Plan:
1. Reset, then write 5 low packets on consecutive cycles, no grants -> slots 0..3 fill, low_count=4, in_ready_low=0 after the 4th write, 5th dropped, high buffer all 0.
2. Low slots 0..3 valid; grant pos=2 low and write a low packet in the same cycle -> the write is dropped (ready=0 that cycle), slot 2 is 0 next cycle, in_ready_low=1; next write lands in slot 2.
3. Low slot 1 valid, no grants, AGE_LIMIT=64, high buffer empty -> promotion completes 65 cycles after the write: high slot 0 holds the packet with identical route info, low slot 1=0, high_count=1, low_count=0.
4. Low slot 1 reaches AGE_LIMIT in the same cycle as grant pos=1 low -> slot cleared, no promotion, high_count stays 0.
5. Grant pos=3 high while high slot 3 is empty, then grant pos=7 -> err_bad_grant=1 and stays 1, buffers unchanged.
6. Two high and one low entry valid, assert flush_req one cycle -> ready outputs 0 from the next cycle; grant all three one per cycle -> flush_done pulses exactly once, one cycle after counts reach 0, then ready outputs return to 1.
